meteor_field: RTL and testbench
===============================

METEOR_FIELD -- requirements
Module: meteor_field

Interface
REQ-001 SHALL have parameter SPAWN_PERIOD, default 60, frames between spawn attempts (range 8..1023).
REQ-002 SHALL have parameter Y_LIMIT, default 480, meteor retire line in pixels.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-004 SHALL have port frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port game_start  in  1  level; starts play from IDLE or OVER.
REQ-007 SHALL have port Ball_die  in  1  player-collision flag from the player-ball stage.
REQ-008 SHALL have port enemy_x[4]  out  10 each  meteor left edge.
REQ-009 SHALL have port enemy_y[4]  out  10 each  meteor top edge.
REQ-010 SHALL have port enemy_size[4]  out  10 each  meteor side length.
REQ-011 SHALL have port enemy_alive[4]  out  1 each  slot active.
REQ-012 SHALL have port dodged_count  out  16  meteors retired without collision.
REQ-013 SHALL have port game_state  out  2  00 IDLE, 01 RUN, 10 OVER.

Function
REQ-014 SHALL hold a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every frame in all states; it SHALL never reach zero.
REQ-015 FSM: IDLE -> RUN on game_start=1; RUN -> OVER on Ball_die=1; OVER -> IDLE on game_start=0; all other cases hold.
REQ-016 On IDLE->RUN: all slots dead, dodged_count=0, spawn timer=SPAWN_PERIOD, same edge.
REQ-017 In RUN, spawn timer SHALL decrement each frame; at value 1 a spawn attempt occurs and the timer reloads with the current period.
REQ-018 Spawn SHALL fill the lowest-index slot dead at start of frame: x = lfsr[8:0]+16, y = 0, size = 8*(lfsr[1:0]+1), speed = lfsr[3:2]+1 (internal, 3 bits).
REQ-019 With all four slots alive, a spawn attempt SHALL be dropped; the timer still reloads.
REQ-020 In RUN, each alive slot SHALL update y <= y+speed using 11-bit sum; if sum >= Y_LIMIT the slot SHALL clear alive and dodged_count SHALL increment by 1.
REQ-021 Multiple retires in one frame SHALL add their count (0..4) to dodged_count, saturating at 16'hFFFF.
REQ-022 A slot retiring in a frame SHALL NOT be reused by a spawn in that same frame.
REQ-023 In OVER, all positions, alive flags and dodged_count SHALL hold; no spawns or moves.
REQ-024 Ball_die=1 in IDLE SHALL be ignored.
REQ-025 Outputs SHALL be registered; enemy_* change one frame_clk edge after the causing condition.
REQ-026 enemy_x, enemy_y, enemy_size of dead slots SHALL hold last values (consumer gates on enemy_alive).

Reset
REQ-027 Reset=0 SHALL immediately force: state IDLE, all enemy_alive=0, enemy_x/y/size=0, dodged_count=0, timer=SPAWN_PERIOD, LFSR=LFSR_SEED, period=SPAWN_PERIOD.
REQ-028 Reset asserted mid-RUN SHALL abort all motion; release requires a new game_start to play.

Configuration
REQ-029 Macro METEOR_SPEEDUP_EN defined: period SHALL decrease by 4 whenever dodged_count crosses a multiple of 16, floor 8; period restores to SPAWN_PERIOD on IDLE->RUN.
REQ-030 Macro METEOR_SPEEDUP_EN undefined: period SHALL stay SPAWN_PERIOD always.

Verification
REQ-031 Reset low, release, game_start=1 one frame -> game_state=01, all alive=0, dodged_count=0.
REQ-032 RUN 60 frames -> slot 0 alive on frame 60, y=0, x in 16..527, size in {8,16,24,32}.
REQ-033 Slot with speed 4 at y=476 -> next frame alive=0, dodged_count+1; slot at y=475 speed 4 retires too (479? no: 479<480 stays alive, retires following frame).
REQ-034 Four slots alive at spawn time -> no slot changes, timer reloads to 60.
REQ-035 Ball_die=1 during RUN -> game_state=10 next edge, enemy_y frozen for 100 frames; game_start=0 -> IDLE.
REQ-036 With METEOR_SPEEDUP_EN, after 16 retires -> next spawn interval 56 frames; after 208 retires -> 8 frames and holds.

Source files
------------

// File: rtl/meteor_field_if.sv
// Bundles meteor_field's game-control inputs with its meteor, score and state outputs.
// The design connects through the slave modport; the player-ball/display side uses master.
interface meteor_field_if;
  logic        game_start;
  logic        Ball_die;
  logic [9:0]  enemy_x     [4];
  logic [9:0]  enemy_y     [4];
  logic [9:0]  enemy_size  [4];
  logic        enemy_alive [4];
  logic [15:0] dodged_count;
  logic [1:0]  game_state;

  modport master (
    output game_start, Ball_die,
    input  enemy_x, enemy_y, enemy_size, enemy_alive, dodged_count, game_state
  );

  modport slave (
    input  game_start, Ball_die,
    output enemy_x, enemy_y, enemy_size, enemy_alive, dodged_count, game_state
  );
endinterface

// File: rtl/meteor_field.sv
// Four-slot falling-meteor field with LFSR spawning and a dodge counter.
// Optional METEOR_SPEEDUP_EN shortens the spawn period every 16 dodges, down to 8 frames.
module meteor_field #(
  parameter int          SPAWN_PERIOD = 60,
  parameter int          Y_LIMIT      = 480,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic           frame_clk,
  input logic           Reset,
  meteor_field_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, OVER = 2'b10} state_t;

  state_t      state, next_state;
  logic [15:0] lfsr;
  logic [9:0]  timer, period;
  logic [9:0]  x_r [4];
  logic [9:0]  y_r [4];
  logic [9:0]  size_r [4];
  logic [2:0]  speed [4];
  logic [3:0]  alive;
  logic [15:0] dodged;

  logic [10:0] sum [4];
  logic [3:0]  retire;
  logic [2:0]  retire_cnt;
  logic [16:0] dodged_sum;
  logic [15:0] dodged_next;
  logic        free_ok;
  logic [1:0]  free_idx;
  logic        start_play;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.game_start)  next_state = RUN;
      RUN:     if (bus.Ball_die)    next_state = OVER;
      OVER:    if (!bus.game_start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign start_play = (state == IDLE) && (next_state == RUN);

  // Free slot is chosen from frame-start liveness, so a slot retiring this frame is never reused.
  always_comb begin
    free_ok    = 1'b0;
    free_idx   = 2'd0;
    retire     = 4'b0000;
    retire_cnt = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!alive[i]) begin
        free_ok  = 1'b1;
        free_idx = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      sum[i]     = {1'b0, y_r[i]} + {8'b0, speed[i]};
      retire[i]  = alive[i] && (sum[i] >= 11'(Y_LIMIT));
      retire_cnt = retire_cnt + {2'b00, retire[i]};
    end
    dodged_sum  = {1'b0, dodged} + {14'b0, retire_cnt};
    dodged_next = dodged_sum[16] ? 16'hFFFF : dodged_sum[15:0];
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      lfsr   <= LFSR_SEED;
      timer  <= 10'(SPAWN_PERIOD);
      alive  <= 4'b0000;
      dodged <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        x_r[i]    <= 10'd0;
        y_r[i]    <= 10'd0;
        size_r[i] <= 10'd0;
        speed[i]  <= 3'd0;
      end
    end else begin
      state <= next_state;
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (start_play) begin
        alive  <= 4'b0000;
        dodged <= 16'd0;
        timer  <= 10'(SPAWN_PERIOD);
      end else if (state == RUN) begin
        for (int i = 0; i < 4; i++) begin
          if (alive[i]) begin
            y_r[i] <= sum[i][9:0];
            if (retire[i]) alive[i] <= 1'b0;
          end
        end
        dodged <= dodged_next;
        if (timer == 10'd1) begin
          timer <= period;
          if (free_ok) begin
            alive[free_idx]  <= 1'b1;
            x_r[free_idx]    <= {1'b0, lfsr[8:0]} + 10'd16;
            y_r[free_idx]    <= 10'd0;
            size_r[free_idx] <= {4'b0, {1'b0, lfsr[1:0]} + 3'd1, 3'b000};
            speed[free_idx]  <= {1'b0, lfsr[3:2]} + 3'd1;
          end
        end else begin
          timer <= timer - 10'd1;
        end
      end
    end
  end

`ifdef METEOR_SPEEDUP_EN
  // A change in dodged[15:4] means the score just crossed a multiple of 16.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      period <= 10'(SPAWN_PERIOD);
    end else if (start_play) begin
      period <= 10'(SPAWN_PERIOD);
    end else if (state == RUN && dodged_next[15:4] != dodged[15:4]) begin
      period <= (period >= 10'd12) ? period - 10'd4 : 10'd8;
    end
  end
`else
  assign period = 10'(SPAWN_PERIOD);
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus.enemy_x[i]     = x_r[i];
      bus.enemy_y[i]     = y_r[i];
      bus.enemy_size[i]  = size_r[i];
      bus.enemy_alive[i] = alive[i];
    end
    bus.dodged_count = dodged;
    bus.game_state   = state;
  end

endmodule

// File: tb/tb_meteor_field.sv
// Randomized self-checking bench for meteor_field against a behavioural game model.
module tb_meteor_field;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b0;
  logic game_start = 1'b0;
  logic ball_die   = 1'b0;

  meteor_field_if bus ();
  assign bus.game_start = game_start;
  assign bus.Ball_die   = ball_die;

  meteor_field dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model: plain integers, game rules applied once per frame.
  int m_state, m_timer, m_lfsr, m_dodged;
  int m_x [4];
  int m_y [4];
  int m_size [4];
  int m_speed [4];
  int m_alive [4];
  int saved_y [4];

  task automatic model_reset();
    m_state = 0; m_timer = 60; m_lfsr = 'hACE1; m_dodged = 0;
    for (int i = 0; i < 4; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_size[i] = 0; m_speed[i] = 0; m_alive[i] = 0;
    end
  endtask

  task automatic model_frame(input int gs, input int bd);
    int cur_lfsr, free, retired, s, fb;
    cur_lfsr = m_lfsr;
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
    if (m_state == 0) begin
      if (gs != 0) begin
        m_state = 1; m_dodged = 0; m_timer = 60;
        for (int i = 0; i < 4; i++) m_alive[i] = 0;
      end
    end else if (m_state == 1) begin
      free = -1;
      for (int i = 0; i < 4; i++) if (free < 0 && m_alive[i] == 0) free = i;
      retired = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_alive[i] != 0) begin
          s = m_y[i] + m_speed[i];
          m_y[i] = s % 1024;
          if (s >= 480) begin
            m_alive[i] = 0;
            retired++;
          end
        end
      end
      m_dodged = (m_dodged + retired > 65535) ? 65535 : m_dodged + retired;
      if (m_timer == 1) begin
        m_timer = 60;
        if (free >= 0) begin
          m_alive[free] = 1;
          m_x[free]     = (cur_lfsr % 512) + 16;
          m_y[free]     = 0;
          m_size[free]  = 8 * ((cur_lfsr % 4) + 1);
          m_speed[free] = ((cur_lfsr / 4) % 4) + 1;
        end
      end else begin
        m_timer--;
      end
      if (bd != 0) m_state = 2;
    end else begin
      if (gs == 0) m_state = 0;
    end
  endtask

  task automatic tick();
    model_frame(int'(game_start), int'(ball_die));
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    compared++;
    if (bus.game_state !== 2'b00 || bus.dodged_count !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: state=%b dodged=%0d required state=00 dodged=0", bus.game_state, bus.dodged_count);
    end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (bus.enemy_alive[i] !== 1'b0 || bus.enemy_x[i] !== 10'd0 || bus.enemy_y[i] !== 10'd0 || bus.enemy_size[i] !== 10'd0) begin
        mismatched++;
        $display("[TB] FAIL reset_slot%0d: alive=%b x=%0d y=%0d size=%0d required all 0", i,
                 bus.enemy_alive[i], bus.enemy_x[i], bus.enemy_y[i], bus.enemy_size[i]);
      end
    end
    @(negedge frame_clk);
    Reset = 1'b1;
  endtask

  task automatic test_idle_ignores_die();
    ball_die = 1'b1;
    for (int f = 0; f < 5; f++) begin
      tick();
      compared++;
      if (bus.game_state !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL idle_die_ignored: state=%b required 00", bus.game_state);
      end
    end
    ball_die = 1'b0;
  endtask

  task automatic test_start();
    game_start = 1'b1;
    tick();
    compared++;
    if (bus.game_state !== 2'b01 || bus.dodged_count !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL start: state=%b dodged=%0d required state=01 dodged=0", bus.game_state, bus.dodged_count);
    end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (bus.enemy_alive[i] !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL start_alive%0d: got %b required 0", i, bus.enemy_alive[i]);
      end
    end
  endtask

  task automatic test_first_spawn();
    for (int f = 1; f <= 60; f++) begin
      game_start = 1'($urandom_range(0, 1));
      tick();
      if (f < 60) begin
        compared++;
        if (bus.enemy_alive[0] !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL early_spawn: frame %0d alive0=%b required 0", f, bus.enemy_alive[0]);
        end
      end
    end
    compared++;
    if (bus.enemy_alive[0] !== 1'b1 || bus.enemy_y[0] !== 10'd0 || bus.enemy_x[0] < 10'd16 || bus.enemy_x[0] > 10'd527 ||
        !(bus.enemy_size[0] inside {10'd8, 10'd16, 10'd24, 10'd32})) begin
      mismatched++;
      $display("[TB] FAIL first_spawn: alive=%b x=%0d y=%0d size=%0d required alive=1 y=0 x 16..527 size 8/16/24/32",
               bus.enemy_alive[0], bus.enemy_x[0], bus.enemy_y[0], bus.enemy_size[0]);
    end
    compared++;
    if (int'(bus.enemy_x[0]) != m_x[0] || int'(bus.enemy_size[0]) != m_size[0]) begin
      mismatched++;
      $display("[TB] FAIL first_spawn_lfsr: x=%0d size=%0d required x=%0d size=%0d",
               bus.enemy_x[0], bus.enemy_size[0], m_x[0], m_size[0]);
    end
  endtask

  task automatic test_random_run(input int frames);
    for (int f = 0; f < frames; f++) begin
      game_start = 1'($urandom_range(0, 1));
      ball_die   = 1'b0;
      tick();
      compared++;
      if (int'(bus.game_state) != m_state || int'(bus.dodged_count) != m_dodged) begin
        mismatched++;
        $display("[TB] FAIL run_score: frame %0d state=%0d dodged=%0d required state=%0d dodged=%0d",
                 f, bus.game_state, bus.dodged_count, m_state, m_dodged);
      end
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (int'(bus.enemy_alive[i]) != m_alive[i] || int'(bus.enemy_x[i]) != m_x[i] ||
            int'(bus.enemy_y[i]) != m_y[i] || int'(bus.enemy_size[i]) != m_size[i]) begin
          mismatched++;
          $display("[TB] FAIL run_slot%0d: frame %0d alive=%b x=%0d y=%0d size=%0d required alive=%0d x=%0d y=%0d size=%0d",
                   i, f, bus.enemy_alive[i], bus.enemy_x[i], bus.enemy_y[i], bus.enemy_size[i],
                   m_alive[i], m_x[i], m_y[i], m_size[i]);
        end
      end
    end
  endtask

  task automatic test_over();
    ball_die = 1'b1;
    tick();
    compared++;
    if (bus.game_state !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL over_enter: state=%b required 10", bus.game_state);
    end
    for (int i = 0; i < 4; i++) saved_y[i] = m_y[i];
    game_start = 1'b1;
    for (int f = 0; f < 100; f++) begin
      ball_die = 1'($urandom_range(0, 1));
      tick();
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (int'(bus.enemy_y[i]) != saved_y[i] || int'(bus.enemy_alive[i]) != m_alive[i] ||
            int'(bus.dodged_count) != m_dodged || bus.game_state !== 2'b10) begin
          mismatched++;
          $display("[TB] FAIL over_frozen%0d: frame %0d y=%0d alive=%b dodged=%0d state=%b required y=%0d alive=%0d dodged=%0d state=10",
                   i, f, bus.enemy_y[i], bus.enemy_alive[i], bus.dodged_count, bus.game_state,
                   saved_y[i], m_alive[i], m_dodged);
        end
      end
    end
    ball_die   = 1'b0;
    game_start = 1'b0;
    tick();
    compared++;
    if (bus.game_state !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL over_to_idle: state=%b required 00", bus.game_state);
    end
  endtask

  task automatic test_mid_reset();
    #2 Reset = 1'b0;
    model_reset();
    #1;
    compared++;
    if (bus.game_state !== 2'b00 || bus.dodged_count !== 16'd0 ||
        bus.enemy_alive[0] !== 1'b0 || bus.enemy_alive[1] !== 1'b0 ||
        bus.enemy_alive[2] !== 1'b0 || bus.enemy_alive[3] !== 1'b0 || bus.enemy_y[0] !== 10'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset: state=%b dodged=%0d alive=%b%b%b%b y0=%0d required all 0",
               bus.game_state, bus.dodged_count, bus.enemy_alive[3], bus.enemy_alive[2],
               bus.enemy_alive[1], bus.enemy_alive[0], bus.enemy_y[0]);
    end
    game_start = 1'b0;
    @(posedge frame_clk);
    #2 Reset = 1'b1;
    @(negedge frame_clk);
    for (int f = 0; f < 70; f++) begin
      tick();
      compared++;
      if (bus.game_state !== 2'b00 || int'(bus.enemy_alive[0]) != m_alive[0]) begin
        mismatched++;
        $display("[TB] FAIL reset_needs_start: frame %0d state=%b alive0=%b required state=00 alive0=0",
                 f, bus.game_state, bus.enemy_alive[0]);
      end
    end
  endtask

  initial begin
    $display("[TB] meteor_field bench start");
    test_reset();
    test_idle_ignores_die();
    test_start();
    test_first_spawn();
    test_random_run(1500);
    test_over();
    test_start();
    test_random_run(300);
    test_mid_reset();
    test_start();
    test_random_run(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
